// File: rtl/rocc_acc_unit_pkg.sv
// Shared types for the RoCC accumulator unit: command/response structs,
// accumulator opcodes and the top-level FSM state encoding.
package rocc_acc_unit_pkg;

    localparam int XLEN = 64;

    typedef struct packed {
        logic [6:0]      funct7;
        logic [4:0]      rd;
        logic            xd;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
    } rocc_cmd_t;

    typedef struct packed {
        logic [4:0]      resp_rd;
        logic [XLEN-1:0] resp_data;
    } rocc_resp_t;

    typedef enum logic [2:0] {
        ACC_LOAD = 3'd0,
        ACC_READ = 3'd1,
        ACC_ADD  = 3'd2,
        ACC_MAC  = 3'd3,
        ACC_CLR  = 3'd4
    } rocc_acc_op_e;

    // Response payload for undefined opcodes or out-of-range accumulator indices
    localparam logic [XLEN-1:0] ACC_ILLEGAL_DATA = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_RESP = 2'd2
    } acc_state_e;

endpackage

// File: rtl/rocc_iter_mul.sv
// Iterative radix-2 shift-add multiplier. Consumes one multiplier bit per
// cycle for DATA_WIDTH cycles and yields the low DATA_WIDTH product bits.
// done_o is high during the final iteration cycle; product_o then already
// includes that last partial product, so the caller can commit on that edge.
module rocc_iter_mul #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] product_o
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

    logic [DATA_WIDTH-1:0] mcand_q;
    logic [DATA_WIDTH-1:0] mplier_q;
    logic [DATA_WIDTH-1:0] prod_q;
    logic [DATA_WIDTH-1:0] prod_next;
    logic [CNT_W-1:0]      cnt_q;
    logic                  running_q;

    // Partial-product accumulation for the current multiplier bit
    always_comb begin
        prod_next = prod_q + (mplier_q[0] ? mcand_q : '0);
    end

    assign done_o    = running_q && (cnt_q == LAST_CNT);
    assign product_o = prod_next;

    // Operand capture on start, then one shift-add step per cycle
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            running_q <= 1'b0;
            cnt_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            prod_q    <= '0;
        end else if (start_i) begin
            running_q <= 1'b1;
            cnt_q     <= '0;
            mcand_q   <= a_i;
            mplier_q  <= b_i;
            prod_q    <= '0;
        end else if (running_q) begin
            prod_q   <= prod_next;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            if (cnt_q == LAST_CNT) begin
                running_q <= 1'b0;
                cnt_q     <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/rocc_acc_unit.sv
// RoCC accumulator accelerator: NUM_ACC accumulators supporting load, read,
// add, multiply-accumulate (iterative) and clear, with a held response
// register that waits for the core's ready.
module rocc_acc_unit
    import rocc_acc_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_ACC    = 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  rocc_cmd_t  rocc_cmd_i,
    input  logic       rocc_cmd_valid_i,
    output logic       rocc_cmd_ready_o,
    output rocc_resp_t rocc_resp_o,
    output logic       rocc_resp_valid_o,
    input  logic       rocc_resp_ready_i,
    output logic       busy_o
);

    localparam int IDX_W = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1;
    localparam logic [4:0] NUM_ACC_L = 5'(NUM_ACC);

    acc_state_e            state_q;
    logic [DATA_WIDTH-1:0] acc_q [NUM_ACC];
    rocc_resp_t            resp_q;
    logic                  resp_valid_q;
    logic [IDX_W-1:0]      mac_idx_q;
    logic [4:0]            mac_rd_q;
    logic                  mac_xd_q;

    logic [2:0]            cmd_op;
    logic [3:0]            cmd_idx_full;
    logic [IDX_W-1:0]      cmd_idx;
    logic                  cmd_legal;
    logic                  cmd_fire;
    logic                  mul_start;
    logic [DATA_WIDTH-1:0] cmd_rs1;
    logic [DATA_WIDTH-1:0] cmd_rs2;
    logic [DATA_WIDTH-1:0] cur_acc;
    logic [DATA_WIDTH-1:0] cmd_new_acc;
    logic [DATA_WIDTH-1:0] cmd_resp_data;
    logic                  mul_done;
    logic [DATA_WIDTH-1:0] mul_product;
    logic [DATA_WIDTH-1:0] mac_sum;

    assign cmd_op       = rocc_cmd_i.funct7[2:0];
    assign cmd_idx_full = rocc_cmd_i.funct7[6:3];
    assign cmd_idx      = cmd_idx_full[IDX_W-1:0];
    assign cmd_rs1      = rocc_cmd_i.rs1_data[DATA_WIDTH-1:0];
    assign cmd_rs2      = rocc_cmd_i.rs2_data[DATA_WIDTH-1:0];
    assign cur_acc      = acc_q[cmd_idx];

    // Legality is judged on the full 4-bit index so e.g. idx 12 with 8 accumulators is rejected
    assign cmd_legal = ({1'b0, cmd_idx_full} < NUM_ACC_L) && (cmd_op <= ACC_CLR);
    assign cmd_fire  = (state_q == ST_IDLE) && rocc_cmd_valid_i;
    assign mul_start = cmd_fire && cmd_legal && (cmd_op == ACC_MAC);
    assign mac_sum   = acc_q[mac_idx_q] + mul_product;

    // Single-cycle op evaluation: new accumulator value and response payload
    always_comb begin
        cmd_new_acc   = cur_acc;
        cmd_resp_data = ACC_ILLEGAL_DATA[DATA_WIDTH-1:0];
        if (cmd_legal) begin
            case (cmd_op)
                ACC_LOAD: begin
                    cmd_new_acc   = cmd_rs1;
                    cmd_resp_data = cmd_rs1;
                end
                ACC_READ: begin
                    cmd_resp_data = cur_acc;
                end
                ACC_ADD: begin
                    cmd_new_acc   = cur_acc + cmd_rs1;
                    cmd_resp_data = cur_acc + cmd_rs1;
                end
                ACC_CLR: begin
                    cmd_resp_data = '0;
                end
                default: begin
                    cmd_resp_data = cur_acc;
                end
            endcase
        end
    end

    rocc_iter_mul #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mul (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (mul_start),
        .a_i       (cmd_rs1),
        .b_i       (cmd_rs2),
        .done_o    (mul_done),
        .product_o (mul_product)
    );

    // Control FSM, accumulator file and held response register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            resp_valid_q <= 1'b0;
            resp_q       <= '0;
            mac_idx_q    <= '0;
            mac_rd_q     <= '0;
            mac_xd_q     <= 1'b0;
            for (int i = 0; i < NUM_ACC; i++) acc_q[i] <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_fire) begin
                        if (mul_start) begin
                            mac_idx_q <= cmd_idx;
                            mac_rd_q  <= rocc_cmd_i.rd;
                            mac_xd_q  <= rocc_cmd_i.xd;
                            state_q   <= ST_MUL;
                        end else begin
                            if (cmd_legal) begin
                                if (cmd_op == ACC_CLR) begin
                                    for (int i = 0; i < NUM_ACC; i++) acc_q[i] <= '0;
                                end else begin
                                    acc_q[cmd_idx] <= cmd_new_acc;
                                end
                            end
                            if (rocc_cmd_i.xd) begin
                                resp_q.resp_rd   <= rocc_cmd_i.rd;
                                resp_q.resp_data <= XLEN'(cmd_resp_data);
                                resp_valid_q     <= 1'b1;
                                state_q          <= ST_RESP;
                            end
                        end
                    end
                end
                ST_MUL: begin
                    if (mul_done) begin
                        acc_q[mac_idx_q] <= mac_sum;
                        if (mac_xd_q) begin
                            resp_q.resp_rd   <= mac_rd_q;
                            resp_q.resp_data <= XLEN'(mac_sum);
                            resp_valid_q     <= 1'b1;
                            state_q          <= ST_RESP;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                ST_RESP: begin
                    if (rocc_resp_ready_i) begin
                        resp_valid_q <= 1'b0;
                        state_q      <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign rocc_cmd_ready_o  = (state_q == ST_IDLE);
    assign busy_o            = (state_q != ST_IDLE);
    assign rocc_resp_valid_o = resp_valid_q;
    assign rocc_resp_o       = resp_q;

endmodule
